// File: rtl/fft_seq_ctrl.sv
// fft_seq_ctrl: job sequencer for the FFT accelerator.
// Accepts a forward/inverse request, waits for a full input frame, loads the
// accel RAM, steps the butterfly datapath through every stage/cycle, drains the
// result to the out FIFO, then pulses done. Every output comes from a flop.
module fft_seq_ctrl #(
  parameter int NUM_STAGES       = 10,
  parameter int CYCLES_PER_STAGE = 512
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        startF,
  input  logic        startI,
  input  logic [17:0] sigNum,
  input  logic        inFifoReady,
  input  logic        loadExternalDone,
  input  logic        writeOutDone,
  output logic        calculating,
  output logic [17:0] sigNumMC,
  output logic        isIFFT,
  output logic        loadExternal,
  output logic        loadInternal,
  output logic [4:0]  stageCount,
  output logic [8:0]  cycleCount,
  output logic        writeOut,
  output logic        done
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_FIFO,
    LOAD,
    CALC,
    WRITE,
    DONE
  } stateT;

  localparam logic [4:0] LAST_STAGE = 5'(NUM_STAGES - 1);
  localparam logic [8:0] LAST_CYCLE = 9'(CYCLES_PER_STAGE - 1);

  stateT       state;
  stateT       stateNext;
  logic [4:0]  stageNext;
  logic [8:0]  cycleNext;
  logic [17:0] sigNumNext;
  logic        isIfftNext;
  logic        calculatingNext;
  logic        loadExternalNext;
  logic        loadInternalNext;
  logic        writeOutNext;
  logic        doneNext;

  // Next-state, next-counter and next-output decode; outputs are a function of
  // the state being entered so that they can be registered alongside it.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; a missing assignment here would infer a latch.
    stateNext  = state;
    stageNext  = '0;
    cycleNext  = '0;
    sigNumNext = sigNumMC;
    isIfftNext = isIFFT;

    unique case (state)
      IDLE: begin
        if (startF || startI) begin
          stateNext  = WAIT_FIFO;
          sigNumNext = sigNum;
          // Forward wins when both requests arrive together.
          isIfftNext = startI & ~startF;
        end
      end
      WAIT_FIFO: begin
        if (inFifoReady) stateNext = LOAD;
      end
      LOAD: begin
        // Counters leave LOAD at zero via the defaults.
        if (loadExternalDone) stateNext = CALC;
      end
      CALC: begin
        if (cycleCount == LAST_CYCLE) begin
          if (stageCount == LAST_STAGE) begin
            stateNext = WRITE;
          end else begin
            stageNext = stageCount + 5'd1;
          end
        end else begin
          stageNext = stageCount;
          cycleNext = cycleCount + 9'd1;
        end
      end
      WRITE: begin
        if (writeOutDone) stateNext = DONE;
      end
      DONE: begin
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase

    calculatingNext  = (stateNext == WAIT_FIFO) || (stateNext == LOAD) ||
                       (stateNext == CALC)      || (stateNext == WRITE);
    loadExternalNext = (stateNext == LOAD);
    loadInternalNext = (stateNext == CALC);
    writeOutNext     = (stateNext == WRITE);
    doneNext         = (stateNext == DONE);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values
      // regardless of statement order.
      state <= stateNext;
    end
  end

  // Registered outputs, counters and the per-job latched request fields.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the latched job fields are reset too, so a job aborted by reset
      // never leaks its signal number or direction into the next one.
      calculating  <= 1'b0;
      sigNumMC     <= 18'h00000;
      isIFFT       <= 1'b0;
      loadExternal <= 1'b0;
      loadInternal <= 1'b0;
      stageCount   <= '0;
      cycleCount   <= '0;
      writeOut     <= 1'b0;
      done         <= 1'b0;
    end else begin
      calculating  <= calculatingNext;
      sigNumMC     <= sigNumNext;
      isIFFT       <= isIfftNext;
      loadExternal <= loadExternalNext;
      loadInternal <= loadInternalNext;
      stageCount   <= stageNext;
      cycleCount   <= cycleNext;
      writeOut     <= writeOutNext;
      done         <= doneNext;
    end
  end

endmodule

// File: doc/fft_seq_ctrl.md
FFT_SEQ_CTRL -- requirements
Module: fft_seq_ctrl

Interface
REQ-001 Parameters: NUM_STAGES, default 10, number of butterfly stages; CYCLES_PER_STAGE, default 512, butterfly cycles per stage.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 startF  input  1  request forward FFT.
REQ-005 startI  input  1  request inverse FFT.
REQ-006 sigNum  input  18  signal number, sampled on accepted start.
REQ-007 inFifoReady  input  1  in FIFO holds a full 1024-sample frame.
REQ-008 loadExternalDone  input  1  accel RAM load from in FIFO complete.
REQ-009 writeOutDone  input  1  out FIFO has drained accel RAM.
REQ-010 calculating  output  1  job in progress.
REQ-011 sigNumMC  output  18  latched signal number for host memory.
REQ-012 isIFFT  output  1  latched transform direction, 1 = inverse.
REQ-013 loadExternal  output  1  load accel RAM from in FIFO.
REQ-014 loadInternal  output  1  butterfly datapath active.
REQ-015 stageCount  output  5  current stage.
REQ-016 cycleCount  output  9  current cycle within stage.
REQ-017 writeOut  output  1  move accel RAM to out FIFO.
REQ-018 done  output  1  single-cycle job-complete pulse.

Function
REQ-019 All outputs SHALL be registered (Moore); no combinational input-to-output path.
REQ-020 The FSM SHALL have states IDLE, WAIT_FIFO, LOAD, CALC, WRITE, DONE.
REQ-021 IDLE: when startF or startI is high at a clock edge, the block SHALL latch sigNum into sigNumMC, set isIFFT = startI & ~startF (startF wins if both are high), set calculating = 1, and move to WAIT_FIFO. All three outputs are valid on the next cycle.
REQ-022 startF and startI SHALL be ignored in every state other than IDLE; sigNumMC and isIFFT SHALL hold for the whole job.
REQ-023 WAIT_FIFO: on inFifoReady = 1, go to LOAD. loadExternal SHALL be 1 starting the cycle after inFifoReady is sampled high.
REQ-024 LOAD: loadExternal SHALL stay 1 up to and including the cycle in which loadExternalDone is sampled high. The next cycle SHALL be CALC with loadExternal = 0, stageCount = 0 and cycleCount = 0.
REQ-025 CALC: loadInternal = 1 every cycle.
- cycleCount increments by 1 each cycle.
- At CYCLES_PER_STAGE-1, cycleCount wraps to 0 and stageCount increments.
REQ-026 CALC exit: at stageCount = NUM_STAGES-1 with cycleCount = CYCLES_PER_STAGE-1, the next state SHALL be WRITE. CALC lasts exactly NUM_STAGES*CYCLES_PER_STAGE cycles (5120 by default).
REQ-027 stageCount and cycleCount SHALL be 0 in every state except CALC; loadInternal SHALL be 0 outside CALC.
REQ-028 WRITE: writeOut SHALL be 1 up to and including the cycle in which writeOutDone is sampled high; then go to DONE.
REQ-029 DONE: done = 1 for exactly one cycle and calculating = 0 in that cycle; then go to IDLE. A new start is accepted the cycle after DONE.
REQ-030 loadExternalDone, writeOutDone and inFifoReady SHALL be ignored outside their own consuming state.
REQ-031 Each of loadExternal, loadInternal and writeOut SHALL be one-hot or all zero at every cycle; no two are ever high together.

Reset
REQ-032 On rst_n low, the block SHALL immediately (asynchronously) enter IDLE. All outputs SHALL be 0, sigNumMC SHALL be 18'h00000, and counters SHALL be 0, including when rst_n falls mid-job.
REQ-033 After rst_n rises, the first start is accepted at the first rising clock edge.

Verification
REQ-034 Full forward job: startF = 1 with sigNum = 18'h00001, then inFifoReady, then loadExternalDone after 128 cycles -> sigNumMC = 1 and calculating = 1 one cycle after start; loadInternal high for exactly 5120 cycles with stage and cycle counts matching a bench counter every cycle; writeOut until writeOutDone; done pulses once and calculating drops.
REQ-035 Simultaneous startF = 1, startI = 1, sigNum = 18'h3FFFF -> isIFFT = 0 and sigNumMC = 18'h3FFFF.
REQ-036 startI with sigNum = 5, then a second start with sigNum = 9 during CALC -> sigNumMC remains 5 and isIFFT remains 1 through done.
REQ-037 Counter wrap: at stage 3, cycle 511 -> next cycle is stage 4, cycle 0. At stage 9, cycle 511 -> next cycle writeOut = 1 and both counters = 0.
REQ-038 rst_n pulled low at stage 5, cycle 100 -> all outputs read 0 in the same cycle. A new startF after reset runs the full job from stage 0.
REQ-039 Stray loadExternalDone or writeOutDone asserted while in IDLE or CALC -> no state change and no output change.
